// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types, constants and helpers for the UART byte blocks.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Receiver framing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Payload bits per character (8N1 framing)
    localparam int DATA_BITS = 8;

    // Rounded sysclk cycles per oversample tick
    function automatic int baud_div(input int clk_hz, input int baud, input int oversample);
        int ticks_per_s;
        ticks_per_s = baud * oversample;
        return (clk_hz + (ticks_per_s / 2)) / ticks_per_s;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_tick
//  Purpose  : Free-running oversample tick generator; a restart realigns the
//             tick phase to the caller's event (e.g. a detected start edge).
//  Revision : 1.0  initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic sysclk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int DIV   = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    // Next count: restart forces phase zero, otherwise wrap at DIV-1
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (restart || (div_cnt_q == C_CNT_LAST)) begin
            div_cnt_d = '0;
        end
    end

    // Divider counter register
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick = (div_cnt_q == C_CNT_LAST);

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_byte
//  Purpose  : 8N1 UART receiver with 16x oversampling, input synchroniser and
//             a one-deep holding buffer acknowledged by the core.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] UART_RXD,
    output logic                 RX_EFF,
    input  logic                 RX_READ,
    output logic                 RX_OVERRUN,
    output logic                 RX_FRAME_ERR
);

    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam logic [SCNT_W-1:0] C_SAMPLE_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] C_SAMPLE_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]        C_BIT_LAST    = 3'(DATA_BITS - 1);

    // Synchroniser
    logic sync1_q;
    logic sync2_q;
    logic rx_s;

    // Framing FSM
    rx_state_t            state_q,      state_d;
    logic [SCNT_W-1:0]    sample_cnt_q, sample_cnt_d;
    logic [2:0]           bit_cnt_q,    bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q,      shreg_d;
    logic                 tick;
    logic                 restart;
    logic                 byte_done;
    logic                 frame_bad;

    // Holding buffer
    logic [DATA_BITS-1:0] rxd_q;
    logic                 eff_q;
    logic                 ovr_q;
    logic                 ferr_q;

    uart_baud_tick #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .sysclk  (sysclk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= UART_RX;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // Next-state logic: mid-bit sampling of start, data and stop bits
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        restart      = 1'b0;
        byte_done    = 1'b0;
        frame_bad    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d      = START;
                    sample_cnt_d = '0;
                    restart      = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (sample_cnt_q == C_SAMPLE_MID) begin
                        if (rx_s) begin
                            // Line went back high before mid-start: glitch
                            state_d = IDLE;
                        end else begin
                            state_d      = DATA;
                            sample_cnt_d = '0;
                            bit_cnt_d    = '0;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (sample_cnt_q == C_SAMPLE_LAST) begin
                        sample_cnt_d = '0;
                        shreg_d      = {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == C_BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (sample_cnt_q == C_SAMPLE_LAST) begin
                        // Return to IDLE at mid-stop so back-to-back starts are caught
                        sample_cnt_d = '0;
                        state_d      = IDLE;
                        if (rx_s) begin
                            byte_done = 1'b1;
                        end else begin
                            frame_bad = 1'b1;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, counters and shift register
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
        end
    end

    // Holding buffer: a new byte and an acknowledge may coincide in one cycle
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rxd_q  <= '0;
            eff_q  <= 1'b0;
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= frame_bad;
            if (byte_done) begin
                rxd_q <= shreg_q;
                eff_q <= 1'b1;
                if (RX_READ) begin
                    ovr_q <= 1'b0;
                end else if (eff_q) begin
                    ovr_q <= 1'b1;
                end
            end else if (RX_READ) begin
                eff_q <= 1'b0;
                ovr_q <= 1'b0;
            end
        end
    end

    assign UART_RXD     = rxd_q;
    assign RX_EFF       = eff_q;
    assign RX_OVERRUN   = ovr_q;
    assign RX_FRAME_ERR = ferr_q;

endmodule : uart_rx_byte
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_byte
//  Purpose  : Directed frames against uart_rx_byte with a queue scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_byte;

    localparam int CLK_HZ     = 1_600_000;
    localparam int BAUD       = 10_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLK    = 160;
    localparam int EV_FERR    = 256;   // scoreboard token for a framing error

    logic       sysclk = 1'b0;
    logic       reset;
    logic       UART_RX;
    logic       RX_READ;
    logic [7:0] UART_RXD;
    logic       RX_EFF;
    logic       RX_OVERRUN;
    logic       RX_FRAME_ERR;

    int checks    = 0;
    int errors    = 0;
    int exp_q[$];
    int fe_cycles = 0;
    int lat       = 0;

    logic [7:0] prev_rxd;
    logic       prev_eff;

    uart_rx_byte #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .UART_RX      (UART_RX),
        .UART_RXD     (UART_RXD),
        .RX_EFF       (RX_EFF),
        .RX_READ      (RX_READ),
        .RX_OVERRUN   (RX_OVERRUN),
        .RX_FRAME_ERR (RX_FRAME_ERR)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name, input logic [31:0] act);
        int e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0h expected nothing", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, act, e);
        end
    endtask

    // One 8N1 character, LSB first; a bad stop bit is low for 100 clk then high
    task automatic send_frame(input logic [7:0] data, input bit good_stop);
        exp_q.push_back(good_stop ? int'(data) : EV_FERR);
        UART_RX = 1'b0;
        repeat (BIT_CLK) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            UART_RX = data[i];
            repeat (BIT_CLK) @(negedge sysclk);
        end
        if (good_stop) begin
            UART_RX = 1'b1;
            repeat (BIT_CLK) @(negedge sysclk);
        end else begin
            UART_RX = 1'b0;
            repeat (100) @(negedge sysclk);
            UART_RX = 1'b1;
            repeat (BIT_CLK - 100) @(negedge sysclk);
        end
    endtask

    task automatic read_pulse();
        RX_READ = 1'b1;
        @(negedge sysclk);
        RX_READ = 1'b0;
    endtask

    // Monitor: every byte load or frame-error pulse is matched against the queue
    always @(negedge sysclk) begin
        if (reset) begin
            prev_rxd = 8'h00;
            prev_eff = 1'b0;
        end else begin
            if (RX_FRAME_ERR) begin
                fe_cycles++;
                pop_check("sb_frame_err", EV_FERR);
            end
            if (RX_EFF && (!prev_eff || (UART_RXD != prev_rxd))) begin
                pop_check("sb_byte", {24'h0, UART_RXD});
            end
            prev_rxd = UART_RXD;
            prev_eff = RX_EFF;
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        reset   = 1'b1;
        UART_RX = 1'b1;
        RX_READ = 1'b0;
        repeat (3) @(negedge sysclk);
        check("reset_rxd",  {24'h0, UART_RXD}, 32'h00);
        check("reset_eff",  {31'h0, RX_EFF}, 32'h0);
        check("reset_ovr",  {31'h0, RX_OVERRUN}, 32'h0);
        check("reset_ferr", {31'h0, RX_FRAME_ERR}, 32'h0);
        reset = 1'b0;
        repeat (20) @(negedge sysclk);

        // 1: 0xA5, latency ~9.5 bit times + sync/register cycles
        fork
            send_frame(8'hA5, 1'b1);
            begin
                lat = 0;
                while (!RX_EFF && lat < 2000) begin
                    @(negedge sysclk);
                    lat++;
                end
                check("t1_latency_window", {31'h0, (lat >= 1520 && lat <= 1530)}, 32'h1);
                check("t1_rxd", {24'h0, UART_RXD}, 32'hA5);
            end
        join
        read_pulse();
        check("t1_eff_cleared", {31'h0, RX_EFF}, 32'h0);
        check("t1_rxd_kept", {24'h0, UART_RXD}, 32'hA5);
        repeat (50) @(negedge sysclk);

        // 2: 40-clk low glitch is rejected, then 0x3C received
        UART_RX = 1'b0;
        repeat (40) @(negedge sysclk);
        UART_RX = 1'b1;
        repeat (300) @(negedge sysclk);
        check("t2_glitch_eff", {31'h0, RX_EFF}, 32'h0);
        send_frame(8'h3C, 1'b1);
        repeat (20) @(negedge sysclk);
        check("t2_rxd", {24'h0, UART_RXD}, 32'h3C);
        check("t2_eff", {31'h0, RX_EFF}, 32'h1);

        // 3: 0x55 with low stop bit; 0x3C stays pending and untouched
        fe_cycles = 0;
        send_frame(8'h55, 1'b0);
        repeat (200) @(negedge sysclk);
        check("t3_ferr_width", fe_cycles, 1);
        check("t3_rxd_kept", {24'h0, UART_RXD}, 32'h3C);
        check("t3_eff_kept", {31'h0, RX_EFF}, 32'h1);
        check("t3_ovr", {31'h0, RX_OVERRUN}, 32'h0);
        read_pulse();
        repeat (20) @(negedge sysclk);

        // 4: back-to-back 0x11, 0x22 without acknowledge -> overrun
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (20) @(negedge sysclk);
        check("t4_rxd", {24'h0, UART_RXD}, 32'h22);
        check("t4_eff", {31'h0, RX_EFF}, 32'h1);
        check("t4_ovr", {31'h0, RX_OVERRUN}, 32'h1);
        read_pulse();
        check("t4_eff_cleared", {31'h0, RX_EFF}, 32'h0);
        check("t4_ovr_cleared", {31'h0, RX_OVERRUN}, 32'h0);
        repeat (20) @(negedge sysclk);

        // 5: acknowledge lands in the same cycle 0x77 loads over pending 0x66
        send_frame(8'h66, 1'b1);
        repeat (20) @(negedge sysclk);
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (lat - 1) @(negedge sysclk);
                check("t5_pending_before", {31'h0, RX_EFF}, 32'h1);
                RX_READ = 1'b1;
                @(negedge sysclk);
                RX_READ = 1'b0;
                check("t5_rxd", {24'h0, UART_RXD}, 32'h77);
                check("t5_eff", {31'h0, RX_EFF}, 32'h1);
                check("t5_ovr", {31'h0, RX_OVERRUN}, 32'h0);
            end
        join
        repeat (20) @(negedge sysclk);

        // 6: reset in the middle of bit 4 of 0x9A; 0x77 is still pending
        UART_RX = 1'b0;
        repeat (BIT_CLK) @(negedge sysclk);
        for (int i = 0; i < 4; i++) begin
            UART_RX = (8'h9A >> i) & 8'h01;
            repeat (BIT_CLK) @(negedge sysclk);
        end
        UART_RX = 1'b1;
        repeat (80) @(negedge sysclk);
        reset = 1'b1;
        #1;
        check("t6_rst_rxd",  {24'h0, UART_RXD}, 32'h00);
        check("t6_rst_eff",  {31'h0, RX_EFF}, 32'h0);
        check("t6_rst_ovr",  {31'h0, RX_OVERRUN}, 32'h0);
        check("t6_rst_ferr", {31'h0, RX_FRAME_ERR}, 32'h0);
        UART_RX = 1'b1;
        repeat (5) @(negedge sysclk);
        reset = 1'b0;
        repeat (200) @(negedge sysclk);
        send_frame(8'hC3, 1'b1);
        repeat (20) @(negedge sysclk);
        check("t6_rxd", {24'h0, UART_RXD}, 32'hC3);
        check("t6_eff", {31'h0, RX_EFF}, 32'h1);
        check("t6_ovr", {31'h0, RX_OVERRUN}, 32'h0);

        repeat (50) @(negedge sysclk);
        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_byte
`default_nettype wire
